reflect_strip_array: RTL and testbench

- Parametrised successor to the fixed three-sensor reflective-strip model in the HIL rig.
- Converts the simulated pod position (nanometres, from the kinematics model) into N laser reflect-sensor outputs.
- Strip pitch, strip width, strip count and per-sensor offsets are configurable.
- Adds per-channel strip counters, minimum-pulse stretching, fault injection and a skipped-strip flag.

---
 rtl/reflect_strip_array.sv | 156 +++++++++++++++
 tb/tb_reflect_strip_array.sv | 138 +++++++++++++
 2 files changed

// File: rtl/reflect_strip_array.sv
// Reflective-strip sensor array: maps pod position to N stretched reflect outputs
// with per-channel strip counting, skip detection and output fault forcing.

module reflect_strip_chan #(
  parameter int              POS_W          = 64,
  parameter int              CNT_W          = 8,
  parameter int              NUM_STRIPS     = 41,
  parameter int              MIN_PULSE_CYC  = 4,
  parameter longint unsigned FIRST_STRIP_NM = 64'd30480000000,
  parameter longint unsigned STRIP_PITCH_NM = 64'd30480000000,
  parameter longint unsigned STRIP_WIDTH_NM = 64'd101600000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             posValid,
  input  logic [POS_W:0]   sensorPos,
  input  logic             faultHi,
  input  logic             faultLo,
  output logic             reflect,
  output logic [CNT_W-1:0] stripCnt,
  output logic             skip,
  output logic             done
);
  localparam int SW = (MIN_PULSE_CYC > 0) ? $clog2(MIN_PULSE_CYC + 1) : 1;
  localparam logic [POS_W:0]   FIRST_E = (POS_W+1)'(FIRST_STRIP_NM);
  localparam logic [POS_W:0]   PITCH_E = (POS_W+1)'(STRIP_PITCH_NM);
  localparam logic [POS_W:0]   WIDTH_E = (POS_W+1)'(STRIP_WIDTH_NM);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(NUM_STRIPS);
  localparam logic [SW-1:0]    PULSE_C = SW'(MIN_PULSE_CYC);

  typedef enum logic [1:0] {BEFORE, ON, DONE} state_t;

  state_t           state, stateNext;
  logic [POS_W:0]   edgeReg, edgeNext, stripEnd;
  logic [CNT_W-1:0] cntInc, cntNext;
  logic             skipNext, passed;
  logic             rawHit, stretched;
  logic [SW-1:0]    strQ, strNext;

  assign stripEnd = edgeReg + WIDTH_E;
  assign cntInc   = (&stripCnt) ? stripCnt : stripCnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BEFORE;
      edgeReg  <= FIRST_E;
      stripCnt <= '0;
      skip     <= 1'b0;
      strQ     <= '0;
      reflect  <= 1'b0;
    end else begin
      state    <= stateNext;
      edgeReg  <= edgeNext;
      stripCnt <= cntNext;
      skip     <= skipNext;
      strQ     <= strNext;
      reflect  <= faultHi ? 1'b1 : faultLo ? 1'b0 : stretched;
    end
  end

  // BEFORE never jumps more than one strip per valid sample, so a large
  // position step is caught up gradually and each missed strip is counted.
  always_comb begin
    stateNext = state;
    edgeNext  = edgeReg;
    cntNext   = stripCnt;
    skipNext  = skip;
    passed    = 1'b0;
    if (posValid) begin
      case (state)
        BEFORE: begin
          if (sensorPos >= stripEnd) begin
            passed   = 1'b1;
            skipNext = 1'b1;
          end else if (sensorPos >= edgeReg) begin
            stateNext = ON;
          end
        end
        ON: begin
          if (sensorPos >= stripEnd) begin
            passed    = 1'b1;
            stateNext = BEFORE;
          end else if (sensorPos < edgeReg) begin
            stateNext = BEFORE;
          end
        end
        default: ;
      endcase
    end
    if (passed) begin
      edgeNext = edgeReg + PITCH_E;
      cntNext  = cntInc;
      if (cntInc >= LAST_C) stateNext = DONE;
    end
  end

  // Stretch counter holds remaining forced-high cycles, including this one.
  always_comb begin
    rawHit    = (stateNext == ON);
    done      = (state == DONE);
    strNext   = '0;
    if (MIN_PULSE_CYC > 0) begin
      if (rawHit && state != ON) strNext = PULSE_C;
      else if (strQ != '0)       strNext = strQ - 1'b1;
    end
    stretched = rawHit | (strNext != '0);
  end
endmodule

module reflect_strip_array #(
  parameter int              NUM_SENSORS    = 3,
  parameter int              POS_W          = 64,
  parameter int              OFS_W          = 32,
  parameter logic [NUM_SENSORS*OFS_W-1:0] SENSOR_OFS_NM =
    {32'd0, 32'd1000000000, 32'd2000000000},
  parameter longint unsigned FIRST_STRIP_NM = 64'd30480000000,
  parameter longint unsigned STRIP_PITCH_NM = 64'd30480000000,
  parameter longint unsigned STRIP_WIDTH_NM = 64'd101600000,
  parameter int              NUM_STRIPS     = 41,
  parameter int              MIN_PULSE_CYC  = 4,
  parameter int              CNT_W          = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [POS_W-1:0]             position,
  input  logic                         pos_valid,
  input  logic [NUM_SENSORS-1:0]       fault_stuck_lo,
  input  logic [NUM_SENSORS-1:0]       fault_stuck_hi,
  output logic [NUM_SENSORS-1:0]       reflect,
  output logic [NUM_SENSORS*CNT_W-1:0] strip_cnt,
  output logic [NUM_SENSORS-1:0]       skip_flag,
  output logic [NUM_SENSORS-1:0]       done
);
  for (genvar i = 0; i < NUM_SENSORS; i++) begin : gCh
    // One extra bit keeps an overflowing sum beyond every strip edge.
    logic [POS_W:0] sensorPos;
    assign sensorPos = {1'b0, position} + (POS_W+1)'(SENSOR_OFS_NM[i*OFS_W +: OFS_W]);

    reflect_strip_chan #(
      .POS_W(POS_W), .CNT_W(CNT_W), .NUM_STRIPS(NUM_STRIPS),
      .MIN_PULSE_CYC(MIN_PULSE_CYC), .FIRST_STRIP_NM(FIRST_STRIP_NM),
      .STRIP_PITCH_NM(STRIP_PITCH_NM), .STRIP_WIDTH_NM(STRIP_WIDTH_NM)
    ) uChan (
      .clk      (clk),
      .rst_n    (rst_n),
      .posValid (pos_valid),
      .sensorPos(sensorPos),
      .faultHi  (fault_stuck_hi[i]),
      .faultLo  (fault_stuck_lo[i]),
      .reflect  (reflect[i]),
      .stripCnt (strip_cnt[i*CNT_W +: CNT_W]),
      .skip     (skip_flag[i]),
      .done     (done[i])
    );
  end
endmodule

// File: tb/tb_reflect_strip_array.sv
// Directed bench for reflect_strip_array with default parameters
// (channel offsets: ch0 = 2e9 nm, ch1 = 1e9 nm, ch2 = 0).

module tb_reflect_strip_array;
  localparam int N  = 3;
  localparam int CW = 8;
  localparam longint unsigned STEP = 64'd2540000;

  logic            clk = 1'b0, rst_n = 1'b0, pos_valid = 1'b0;
  logic [63:0]     position = '0;
  logic [N-1:0]    fault_stuck_lo = '0, fault_stuck_hi = '0;
  logic [N-1:0]    reflect, skip_flag, done;
  logic [N*CW-1:0] strip_cnt;
  int nCmp = 0, nErr = 0;

  always #5 clk = ~clk;

  reflect_strip_array dut (
    .clk(clk), .rst_n(rst_n), .position(position), .pos_valid(pos_valid),
    .fault_stuck_lo(fault_stuck_lo), .fault_stuck_hi(fault_stuck_hi),
    .reflect(reflect), .strip_cnt(strip_cnt), .skip_flag(skip_flag), .done(done)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [63:0] p);
    position = p; pos_valid = 1'b1; tick(); pos_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0; pos_valid = 1'b0; tick(); rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] e;
    // reset state
    tick(); doReset();
    chk("rst_reflect", reflect, 0); chk("rst_cnt", strip_cnt, 0);
    chk("rst_skip", skip_flag, 0);  chk("rst_done", done, 0);

    // slow traverse of strip 0 in 2.54e6 nm steps
    for (int n = 0; n <= 12041; n++) begin
      position = 64'(n) * STEP; pos_valid = 1'b1; tick(); pos_valid = 1'b0;
      if (n inside {11212, 11213, 11252, 11253, 11606, 11607,
                    11646, 11647, 11999, 12000, 12039, 12040}) begin
        e[0] = (n >= 11213 && n < 11253);
        e[1] = (n >= 11607 && n < 11647);
        e[2] = (n >= 12000 && n < 12040);
        chk($sformatf("trav_n%0d", n), reflect, e);
      end
      if (n >= 11000) repeat (3) tick();
      if (n == 12020) chk("trav_hold_idle", reflect, 3'b100);
    end
    chk("trav_cnt", strip_cnt, 24'h010101);
    chk("trav_skip", skip_flag, 0);
    chk("trav_done", done, 0);

    // jump over strips: one catch-up strip per valid sample
    doReset();
    sample(64'd27000000000);
    chk("jump_pre_cnt", strip_cnt, 0);
    sample(64'd61000000000);
    chk("jump_a_cnt", strip_cnt, 24'h010101);
    chk("jump_a_skip", skip_flag, 3'b111);
    chk("jump_a_refl", reflect, 0);
    sample(64'd61000000000);
    chk("jump_b_cnt", strip_cnt, 24'h010202);
    chk("jump_b_refl", reflect, 3'b100);

    // minimum pulse stretch on ch2
    doReset();
    sample(64'd30500000000); chk("str_e0", reflect[2], 1);
    tick();                  chk("str_e1", reflect[2], 1);
    sample(64'd30600000000); chk("str_e2", reflect[2], 1);
    tick();                  chk("str_e3", reflect[2], 1);
    tick();                  chk("str_e4", reflect[2], 0);
    chk("str_cnt", strip_cnt, 24'h010101);
    chk("str_skip", skip_flag, 3'b011);

    // output faults mask reflect only
    doReset();
    fault_stuck_hi = 3'b010; fault_stuck_lo = 3'b100;
    tick();                  chk("flt_apply", reflect, 3'b010);
    sample(64'd28480000000); chk("flt_e0", reflect, 3'b011);
    sample(64'd29500000000); chk("flt_e1", reflect, 3'b011);
    sample(64'd30500000000); chk("flt_e2", reflect, 3'b011);
    sample(64'd30600000000); chk("flt_e3", reflect, 3'b011);
    chk("flt_cnt", strip_cnt, 24'h010101);
    chk("flt_skip", skip_flag, 0);
    tick();                  chk("flt_e4", reflect, 3'b010);
    fault_stuck_hi = '0; fault_stuck_lo = '0;
    repeat (2) tick();       chk("flt_clear", reflect, 0);

    // drive past the last strip
    doReset();
    position = 64'd1300000000000; pos_valid = 1'b1;
    repeat (40) tick();
    chk("done_40_cnt", strip_cnt, 24'h282828);
    chk("done_40_done", done, 0);
    tick();
    chk("done_41_cnt", strip_cnt, 24'h292929);
    chk("done_41_done", done, 3'b111);
    repeat (3) tick();
    chk("done_hold_cnt", strip_cnt, 24'h292929);
    position = 64'd1280200000000; tick();
    chk("done_refl", reflect, 0);
    chk("done_hold2", strip_cnt, 24'h292929);
    pos_valid = 1'b0;

    // reset mid-pulse
    doReset();
    position = 64'd121950000000; pos_valid = 1'b1;
    repeat (4) tick();
    pos_valid = 1'b0;
    chk("mid_refl", reflect, 3'b100);
    chk("mid_cnt", strip_cnt, 24'h030404);
    rst_n = 1'b0; tick();
    chk("mid_rst_refl", reflect, 0); chk("mid_rst_cnt", strip_cnt, 0);
    chk("mid_rst_skip", skip_flag, 0); chk("mid_rst_done", done, 0);
    rst_n = 1'b1;
    sample(64'd30500000000);
    chk("restart_refl", reflect, 3'b100);
    chk("restart_cnt", strip_cnt, 24'h000101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
